// File: rtl/branch_resolve_queue.sv
// In-order queue of fetched instructions and their predicted next PCs. It checks each
// resolved next PC against the prediction, trains the predictor and redirects fetch on a miss.
module branch_resolve_queue #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instr,
  input  logic [31:0]      push_pred_pc,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  input  logic             resolve_valid,
  input  logic [31:0]      resolve_next_pc,
  output logic             upd_valid,
  output logic             miss,
  output logic [31:0]      last_pc,
  output logic [31:0]      last_instr,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_pc_mem   [DEPTH];
  logic [31:0] r_instr_mem[DEPTH];
  logic [31:0] r_pred_mem [DEPTH];

  // The extra pointer bit tells a full queue apart from an empty one.
  logic [CNT_W-1:0] r_head;
  logic [CNT_W-1:0] r_tail;

  logic [CNT_W-1:0] w_count;
  logic [PTR_W-1:0] w_head_idx;
  logic [PTR_W-1:0] w_tail_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_mis;
  logic             w_push;

  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == CNT_W'(DEPTH));
  assign w_empty    = (w_count == CNT_W'(0));
  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_tail_idx = r_tail[PTR_W-1:0];

  assign w_pop  = resolve_valid && !w_empty;
  assign w_mis  = w_pop && (resolve_next_pc != r_pred_mem[w_head_idx]);
  assign w_push = en && (r_state == ST_RUN) && !w_mis && (!w_full || w_pop);

  assign full  = w_full;
  assign empty = w_empty;
  assign count = w_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DRAIN lasts one cycle and covers the redirect's trip back to fetch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_mis) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // A miss makes every younger entry wrong-path, so it wipes the whole queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (w_mis) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + CNT_W'(1);
      if (w_pop)  r_head <= r_head + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[w_tail_idx]    <= push_pc;
      r_instr_mem[w_tail_idx] <= push_instr;
      r_pred_mem[w_tail_idx]  <= push_pred_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid      <= 1'b0;
      miss           <= 1'b0;
      last_pc        <= '0;
      last_instr     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      upd_valid      <= w_pop;
      miss           <= w_mis;
      redirect_valid <= w_mis;
      if (w_pop) begin
        last_pc    <= r_pc_mem[w_head_idx];
        last_instr <= r_instr_mem[w_head_idx];
      end
      if (w_mis) redirect_pc <= resolve_next_pc;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a vector table plus hand-written sequences
// for fill, wrap, asynchronous reset and flush corners.
module tb_branch_resolve_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned NVEC  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [31:0]      push_pc = '0;
  logic [31:0]      push_instr = '0;
  logic [31:0]      push_pred_pc = '0;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             resolve_valid = 1'b0;
  logic [31:0]      resolve_next_pc = '0;
  logic             upd_valid;
  logic             miss;
  logic [31:0]      last_pc;
  logic [31:0]      last_instr;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  int errors = 0;
  int checks = 0;

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en),
    .push_pc(push_pc), .push_instr(push_instr), .push_pred_pc(push_pred_pc),
    .full(full), .empty(empty), .count(count),
    .resolve_valid(resolve_valid), .resolve_next_pc(resolve_next_pc),
    .upd_valid(upd_valid), .miss(miss), .last_pc(last_pc), .last_instr(last_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] pred;
    logic        rv;
    logic [31:0] rnext;
    int unsigned cnt;
    logic        upd;
    logic        mis;
    logic [31:0] lpc;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic e, input logic [31:0] pc, input logic [31:0] pred,
                              input logic rv, input logic [31:0] rn, input int unsigned cnt,
                              input logic upd, input logic mis, input logic [31:0] lpc,
                              input logic redir, input logic [31:0] rpc);
    vec_t v;
    v.en = e; v.pc = pc; v.pred = pred; v.rv = rv; v.rnext = rn;
    v.cnt = cnt; v.upd = upd; v.mis = mis; v.lpc = lpc; v.redir = redir; v.rpc = rpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] pc, input logic [31:0] pred,
                       input logic rv, input logic [31:0] rn);
    en              = e;
    push_pc         = pc;
    push_instr      = ~pc;
    push_pred_pc    = pred;
    resolve_valid   = rv;
    resolve_next_pc = rn;
  endtask

  task automatic check_state(input string tag, input int unsigned cnt, input logic upd,
                             input logic mis, input logic [31:0] lpc, input logic redir,
                             input logic [31:0] rpc);
    check({tag, " count"}, 32'(count), cnt);
    check({tag, " empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, " full"}, 32'(full), 32'(cnt == DEPTH));
    check({tag, " upd_valid"}, 32'(upd_valid), 32'(upd));
    check({tag, " miss"}, 32'(miss), 32'(mis));
    check({tag, " last_pc"}, last_pc, lpc);
    check({tag, " redirect_valid"}, 32'(redirect_valid), 32'(redir));
    check({tag, " redirect_pc"}, redirect_pc, rpc);
    if (upd) check({tag, " last_instr"}, last_instr, ~lpc);
  endtask

  logic [31:0] q_pc[$];
  logic [31:0] exp_pc;
  logic [31:0] new_pc;

  initial begin
    // in-order resolves, a mispredict with flush and DRAIN, then resolves on an empty queue
    vecs[0]  = mk(1, 32'h100, 32'h104, 0, 0,          1, 0, 0, 32'h0,   0, 32'h0);
    vecs[1]  = mk(1, 32'h104, 32'h108, 0, 0,          2, 0, 0, 32'h0,   0, 32'h0);
    vecs[2]  = mk(1, 32'h108, 32'h10C, 0, 0,          3, 0, 0, 32'h0,   0, 32'h0);
    vecs[3]  = mk(0, 32'h0,   32'h0,   1, 32'h104,    2, 1, 0, 32'h100, 0, 32'h0);
    vecs[4]  = mk(0, 32'h0,   32'h0,   1, 32'h108,    1, 1, 0, 32'h104, 0, 32'h0);
    vecs[5]  = mk(0, 32'h0,   32'h0,   1, 32'h10C,    0, 1, 0, 32'h108, 0, 32'h0);
    vecs[6]  = mk(0, 32'h0,   32'h0,   0, 0,          0, 0, 0, 32'h108, 0, 32'h0);
    vecs[7]  = mk(1, 32'h200, 32'h204, 0, 0,          1, 0, 0, 32'h108, 0, 32'h0);
    vecs[8]  = mk(1, 32'h204, 32'h208, 0, 0,          2, 0, 0, 32'h108, 0, 32'h0);
    vecs[9]  = mk(1, 32'h208, 32'h20C, 0, 0,          3, 0, 0, 32'h108, 0, 32'h0);
    vecs[10] = mk(1, 32'h20C, 32'h210, 1, 32'h300,    0, 1, 1, 32'h200, 1, 32'h300);
    vecs[11] = mk(1, 32'h400, 32'h404, 0, 0,          0, 0, 0, 32'h200, 0, 32'h300);
    vecs[12] = mk(1, 32'h400, 32'h404, 0, 0,          1, 0, 0, 32'h200, 0, 32'h300);
    vecs[13] = mk(0, 32'h0,   32'h0,   1, 32'h404,    0, 1, 0, 32'h400, 0, 32'h300);
    vecs[14] = mk(0, 32'h0,   32'h0,   1, 32'h999,    0, 0, 0, 32'h400, 0, 32'h300);
    vecs[15] = mk(1, 32'h0,   32'h0,   0, 0,          1, 0, 0, 32'h400, 0, 32'h300);

    tick;
    tick;
    check_state("reset", 0, 0, 0, 32'h0, 0, 32'h0);
    reset = 1'b0;
    tick;
    check_state("post_reset", 0, 0, 0, 32'h0, 0, 32'h0);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].en, vecs[i].pc, vecs[i].pred, vecs[i].rv, vecs[i].rnext);
      tick;
      check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].upd, vecs[i].mis,
                  vecs[i].lpc, vecs[i].redir, vecs[i].rpc);
    end

    // fill from a clean reset, then stream push+pop across the pointer wrap
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    check("fill start count", 32'(count), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      new_pc = 32'h1000 + 32'(4 * i);
      drive(1, new_pc, new_pc + 32'd4, 0, 0);
      q_pc.push_back(new_pc);
      tick;
      check($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
    end
    check("fill full", 32'(full), 32'd1);
    drive(1, 32'h2000, 32'h2004, 0, 0);
    tick;
    check("refused count", 32'(count), DEPTH);
    check("refused full", 32'(full), 32'd1);
    check("refused upd", 32'(upd_valid), 32'd0);

    for (int i = 0; i < 20; i++) begin
      new_pc = 32'h1100 + 32'(4 * i);
      exp_pc = q_pc.pop_front();
      q_pc.push_back(new_pc);
      drive(1, new_pc, new_pc + 32'd4, 1, exp_pc + 32'd4);
      tick;
      check($sformatf("wrap%0d upd", i), 32'(upd_valid), 32'd1);
      check($sformatf("wrap%0d miss", i), 32'(miss), 32'd0);
      check($sformatf("wrap%0d last_pc", i), last_pc, exp_pc);
      check($sformatf("wrap%0d last_instr", i), last_instr, ~exp_pc);
      check($sformatf("wrap%0d count", i), 32'(count), DEPTH);
    end

    for (int i = 0; i < 3; i++) begin
      exp_pc = q_pc.pop_front();
      drive(0, 0, 0, 1, exp_pc + 32'd4);
      tick;
      check($sformatf("drain%0d last_pc", i), last_pc, exp_pc);
    end
    check("pre_reset count", 32'(count), 32'd5);

    // asynchronous reset mid-cycle while a mismatching resolve is presented
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    #3;
    reset = 1'b1;
    #1;
    check_state("async_reset", 0, 0, 0, 32'h0, 0, 32'h0);
    check("async_reset last_instr", last_instr, 32'h0);
    drive(0, 0, 0, 0, 0);
    tick;
    reset = 1'b0;
    tick;
    check_state("after_release", 0, 0, 0, 32'h0, 0, 32'h0);

    // mismatch on the only entry while a push is offered: the push is dropped
    drive(1, 32'h500, 32'h504, 0, 0);
    tick;
    check("last_entry count", 32'(count), 32'd1);
    drive(1, 32'h600, 32'h604, 1, 32'h777);
    tick;
    check_state("last_mis", 0, 1, 1, 32'h500, 1, 32'h777);
    drive(1, 32'h700, 32'h704, 0, 0);
    tick;
    check_state("last_drain", 0, 0, 0, 32'h500, 0, 32'h777);
    tick;
    check_state("last_resume", 1, 0, 0, 32'h500, 0, 32'h777);
    drive(0, 0, 0, 1, 32'h704);
    tick;
    check_state("last_pop", 0, 1, 0, 32'h700, 0, 32'h777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Backend counterpart of the frontend branch predictor.
- Records every fetched instruction with its predicted next PC. When execute resolves the oldest in-flight instruction, compares actual vs predicted next PC.
- Drives the predictor training port (miss, last_pc, last_instr) and issues a fetch redirect plus wrong-path flush on a mismatch.
- Sits between the fetch stage (push side) and the execute stage (resolve side).

Parameters:
DEPTH, 8, in-flight entries; power of 2, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, do not override)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
en  in  1  fetch push request for this cycle
push_pc  in  32  PC of fetched instruction
push_instr  in  32  fetched instruction word
push_pred_pc  in  32  predictor's next-PC for this instruction
full  out  1  queue full; push refused
empty  out  1  queue empty
count  out  PTR_W+1  occupied entries
resolve_valid  in  1  execute resolved the oldest in-flight instruction
resolve_next_pc  in  32  actual next PC of that instruction
upd_valid  out  1  training update valid (registered pulse)
miss  out  1  update was a misprediction (registered)
last_pc  out  32  PC of resolved instruction (registered)
last_instr  out  32  instruction word of resolved instruction (registered)
redirect_valid  out  1  fetch redirect pulse (registered)
redirect_pc  out  32  redirect target (registered)

Behaviour:
- Reset: head = tail = count = 0; state RUN; empty = 1, full = 0. upd_valid, miss, redirect_valid = 0. last_pc, last_instr, redirect_pc = 0. Async assert, clean release on clk.
- Storage: circular buffer of {pc, instr, pred_pc}. Head = oldest. Pointers wrap modulo DEPTH. count = tail - head, tracked with an extra bit. full = (count == DEPTH), empty = (count == 0). All three are combinational from registered state.
- Pop: pop = resolve_valid && !empty. resolve_valid while empty is ignored; outputs stay 0.
- Compare: mis = pop && (resolve_next_pc != head.pred_pc), a full 32-bit compare.
- Push: push = en && state==RUN && !mis && (!full || pop). Simultaneous push and pop when full is allowed; count is unchanged.
- Training outputs, 1-cycle latency: on the edge after a pop, upd_valid = 1, miss = mis, last_pc = head.pc, last_instr = head.instr. Without a pop, upd_valid = 0 and miss = 0; last_pc/last_instr hold their values.
- Redirect on mis, same edge as training outputs:
  - redirect_valid = 1, redirect_pc = resolve_next_pc.
  - head = tail = count = 0 (all younger entries are wrong-path).
  - Any push in that cycle is dropped.
  - State goes to DRAIN.
- redirect_valid is a single-cycle pulse; redirect_pc holds its value until the next redirect.
- State machine:
  - RUN: normal push/pop; mis -> DRAIN.
  - DRAIN: exactly one cycle. Pushes are blocked because fetch is still on the wrong path while the redirect propagates. Pops are impossible since the queue is empty. Always -> RUN.
- Priority within a cycle: reset > mis flush > push/pop.
- Reset mid-operation: all entries are discarded, with no update or redirect pulse.

Test Plan:
- Reset, then push pc=0x100/pred 0x104, 0x104/pred 0x108, 0x108/pred 0x10C -> count=3. Resolve 0x104, 0x108, 0x10C on consecutive cycles -> three upd_valid pulses, miss=0, last_pc 0x100/0x104/0x108 one cycle late; empty=1 afterwards.
- Push 3 entries; resolve the head with 0x200 ≠ pred 0x104 while en=1 -> next cycle: miss=1, last_pc=0x100, redirect_valid=1, redirect_pc=0x200, count=0. The following cycle en=1 is ignored (DRAIN, count stays 0). The cycle after that, a push is accepted.
- Push DEPTH=8 entries -> full=1, a 9th push is refused. Then push + correct resolve in the same cycle -> count stays 8, tail wraps to 0. Continue 20 cycles of push+pop with correct predictions -> FIFO order preserved across wrap, no misses.
- resolve_valid=1 with the queue empty -> upd_valid=0, miss=0, count=0, no redirect.
- Assert reset asynchronously mid-clock with 5 entries queued and a pending mismatch -> outputs go to 0 immediately, count=0, no redirect pulse after release.
- Mismatch on the last remaining entry with a simultaneous push -> push dropped, count=0, redirect_pc = resolve_next_pc.
